// File: rtl/key_repeat_pulser_pkg.sv
// Shared types and default timing for the key repeat pulser.
// Defaults assume a 50 MHz system clock.
package key_repeat_pulser_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam int DEBOUNCE_DEF = 500000;
  localparam int HOLD_DEF     = 25000000;
  localparam int REPEAT_DEF   = 5000000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_repeat_pulser_sync2.sv
// Two-flop synchronizer for an asynchronous level.
// Both flops reset to a selectable value.
module key_repeat_pulser_sync2
  import key_repeat_pulser_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the raw input
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_repeat_pulser.sv
// Debounced key to single-cycle enable pulses with auto-repeat.
// One shared counter times debounce, hold and repeat intervals.
module key_repeat_pulser
  import key_repeat_pulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES     = HOLD_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  input  logic enable_in,
  output logic pulse,
  output logic pressed,
  output logic repeating
);

  localparam int CW = $clog2(max3(
    DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [CW-1:0] DB_TC =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC =
    CW'(REPEAT_CYCLES - 1);

  logic          key_s;
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          fire;

  key_repeat_pulser_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clock (clock),
    .resetn(resetn),
    .d     (key_n),
    .q     (key_s)
  );

  // next state, shared counter and pulse request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TC) begin
          state_d = REPEAT;
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      REPEAT: begin
        if (key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == REP_TC) begin
          cnt_d = '0;
          fire  = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse     <= 1'b0;
      pressed   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse     <= fire & enable_in;
      pressed   <= (state_d == HELD) ||
                   (state_d == REPEAT) ||
                   (state_d == DB_RELEASE);
      repeating <= (state_d == REPEAT);
    end
  end

endmodule

// File: tb/tb_key_repeat_pulser.sv
// Scoreboard bench for key_repeat_pulser.
// Expected pulse edges are queued as stimulus is driven.
module tb_key_repeat_pulser;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic key_n = 1'b1;
  logic enable_in = 1'b1;
  logic pulse;
  logic pressed;
  logic repeating;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int e0 = 0;
  int q[$];

  key_repeat_pulser #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .key_n    (key_n),
    .enable_in(enable_in),
    .pulse    (pulse),
    .pressed  (pressed),
    .repeating(repeating)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input int          exp
  );
    checks++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // every pulse must match the oldest queued edge
  always @(negedge clock) begin : mon
    int e;
    if (pulse === 1'b1) begin
      if (q.size() > 0) e = q.pop_front();
      else e = -1;
      chk("pulse_cyc", cyc, e);
    end
  end

  task automatic run_hold(input logic en);
    enable_in = en;
    key_n = 1'b0;
    e0 = cyc + 1;
    if (en) begin
      q.push_back(e0 + D + 2);
      for (int k = 0; k < 5; k++)
        q.push_back(e0 + D + 2 + H + k * R);
    end
    wait_cyc(e0 + 5);
    chk("hold_prs_pre", pressed, 0);
    wait_cyc(e0 + 6);
    chk("hold_prs", pressed, 1);
    chk("hold_rep0", repeating, 0);
    wait_cyc(e0 + 25);
    chk("hold_rep_pre", repeating, 0);
    wait_cyc(e0 + 26);
    chk("hold_rep", repeating, 1);
    wait_cyc(e0 + 59);
    key_n = 1'b1;
    wait_cyc(e0 + 61);
    chk("hold_rep_end", repeating, 1);
    wait_cyc(e0 + 62);
    chk("rel_rep", repeating, 0);
    chk("rel_prs", pressed, 1);
    wait_cyc(e0 + 80);
    chk("hold_prs_off", pressed, 0);
    chk("hold_sb", q.size(), 0);
    enable_in = 1'b1;
  endtask

  initial begin
    tick(2);
    chk("rst_pulse", pulse, 0);
    chk("rst_prs", pressed, 0);
    chk("rst_rep", repeating, 0);
    resetn = 1'b1;
    tick(3);

    // clean 12-cycle press
    key_n = 1'b0;
    e0 = cyc + 1;
    q.push_back(e0 + D + 2);
    wait_cyc(e0 + 5);
    chk("s1_prs_pre", pressed, 0);
    wait_cyc(e0 + 6);
    chk("s1_prs", pressed, 1);
    chk("s1_rep", repeating, 0);
    wait_cyc(e0 + 11);
    key_n = 1'b1;
    wait_cyc(e0 + 30);
    chk("s1_prs_off", pressed, 0);
    chk("s1_sb", q.size(), 0);

    // bouncing key never qualifies
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      tick(2);
      chk("bnc_prs", pressed, 0);
      key_n = 1'b1;
      tick(2);
      chk("bnc_prs", pressed, 0);
      chk("bnc_rep", repeating, 0);
    end
    tick(10);
    chk("bnc_prs_end", pressed, 0);

    // long hold with auto-repeat
    run_hold(1'b1);

    // short release glitch restarts hold timer
    key_n = 1'b0;
    e0 = cyc + 1;
    q.push_back(e0 + 6);
    q.push_back(e0 + 41);
    q.push_back(e0 + 49);
    wait_cyc(e0 + 16);
    key_n = 1'b1;
    wait_cyc(e0 + 18);
    key_n = 1'b0;
    wait_cyc(e0 + 20);
    chk("gl_prs", pressed, 1);
    wait_cyc(e0 + 26);
    chk("gl_rep_pre", repeating, 0);
    wait_cyc(e0 + 41);
    chk("gl_rep", repeating, 1);
    wait_cyc(e0 + 50);
    key_n = 1'b1;
    wait_cyc(e0 + 70);
    chk("gl_prs_off", pressed, 0);
    chk("gl_sb", q.size(), 0);

    // gated hold: no pulses, same levels
    run_hold(1'b0);

    // reset mid-repeat with key held
    key_n = 1'b0;
    e0 = cyc + 1;
    q.push_back(e0 + 6);
    q.push_back(e0 + 26);
    wait_cyc(e0 + 31);
    chk("rr_rep_pre", repeating, 1);
    resetn = 1'b0;
    #1;
    chk("rr_pulse", pulse, 0);
    chk("rr_prs", pressed, 0);
    chk("rr_rep", repeating, 0);
    wait_cyc(e0 + 33);
    resetn = 1'b1;
    q.push_back(e0 + 40);
    wait_cyc(e0 + 39);
    chk("rr_prs_pre", pressed, 0);
    wait_cyc(e0 + 40);
    chk("rr_prs_new", pressed, 1);
    wait_cyc(e0 + 45);
    key_n = 1'b1;
    wait_cyc(e0 + 65);
    chk("rr_prs_off", pressed, 0);
    chk("rr_sb", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
